parity_rr_sched: RTL and testbench

- Shares one odd-parity evaluation datapath (XOR-reduce of a DW-bit word) between NREQ requesters.
- Requester i presents a data word plus an expected parity bit and holds req[i].
- The block grants round-robin, captures the word, computes parity, and returns the result with a one-cycle done pulse.
- Keeps a saturating error counter. Sits between the nibble producers and the status/CSR logic.

---
 rtl/parity_rr_sched_if.sv | 31 +++
 rtl/parity_rr_sched.sv | 146 ++++++++++++++
 tb/tb_parity_rr_sched.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/parity_rr_sched_if.sv
// Requester/status bus for the shared odd-parity checker.
// The requester side drives req/data/exp_par/clr_cnt; the scheduler drives grants and results.
interface parity_rr_sched_if #(
    parameter int NREQ = 4,
    parameter int DW   = 4,
    parameter int IDW  = 2,
    parameter int CW   = 8
) ();
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] data;
    logic [NREQ-1:0]    exp_par;
    logic               clr_cnt;

    logic [NREQ-1:0]    gnt;
    logic               busy;
    logic               done;
    logic [IDW-1:0]     done_id;
    logic               par_out;
    logic               err;
    logic [CW-1:0]      err_cnt;

    modport master (
        output req, data, exp_par, clr_cnt,
        input  gnt, busy, done, done_id, par_out, err, err_cnt
    );

    modport slave (
        input  req, data, exp_par, clr_cnt,
        output gnt, busy, done, done_id, par_out, err, err_cnt
    );
endinterface

// File: rtl/parity_rr_sched.sv
// Round-robin scheduler sharing one odd-parity evaluator between NREQ requesters.
// Each check takes IDLE -> CAPT -> CALC; results and a one-cycle done strobe follow.
module parity_rr_sched #(
    parameter int NREQ = 4,
    parameter int DW   = 4,
    parameter int IDW  = 2,
    parameter int CW   = 8
) (
    input  logic               clk,
    input  logic               rst,
    parity_rr_sched_if.slave   bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CAPT = 2'd1;
    localparam logic [1:0] S_CALC = 2'd2;

    localparam logic [CW-1:0]  CNT_MAX  = '1;
    localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

    logic [1:0]      r_state;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_id;
    logic [DW-1:0]   r_data;
    logic            r_exp;
    logic [NREQ-1:0] r_gnt;
    logic            r_busy;
    logic            r_done;
    logic [IDW-1:0]  r_done_id;
    logic            r_par;
    logic            r_err;
    logic [CW-1:0]   r_cnt;

    logic [NREQ-1:0] w_mask;
    logic [NREQ-1:0] w_elig;
    logic            w_found;
    logic [IDW-1:0]  w_win;
    logic [NREQ-1:0] w_win_oh;
    logic [DW-1:0]   w_word;
    logic            w_exp;
    logic [IDW-1:0]  w_ptr_nxt;

    // The requester whose done is still showing must not win again in that same cycle.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_done && (r_done_id == IDW'(i))) w_mask[i] = 1'b1;
        end
        w_elig   = bus.req & ~w_mask;
        w_found  = 1'b0;
        w_win    = '0;
        w_win_oh = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && w_elig[(int'(r_ptr) + k) % NREQ]) begin
                w_found = 1'b1;
                w_win   = IDW'((int'(r_ptr) + k) % NREQ);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == IDW'(i)) w_win_oh[i] = w_found;
        end
    end

    always_comb begin
        w_word = '0;
        w_exp  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_id == IDW'(i)) begin
                w_word = bus.data[i*DW +: DW];
                w_exp  = bus.exp_par[i];
            end
        end
    end

    assign w_ptr_nxt = (r_id == LAST_IDX) ? '0 : r_id + 1'b1;

    // NOTE: control/state uses non-blocking assignments only; sequential blocks never use '='.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= '0;
            r_par     <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt   <= w_win_oh;
                        r_busy  <= 1'b1;
                        r_state <= S_CAPT;
                    end
                end
                S_CAPT: begin
                    r_state <= S_CALC;
                end
                S_CALC: begin
                    r_par     <= ^r_data;
                    r_err     <= (^r_data) ^ r_exp;
                    r_done    <= 1'b1;
                    r_done_id <= r_id;
                    r_gnt     <= '0;
                    r_busy    <= 1'b0;
                    r_ptr     <= w_ptr_nxt;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase

            // Clear beats a coincident error; the count sticks at its maximum.
            if (bus.clr_cnt) begin
                r_cnt <= '0;
            end else if (r_done && r_err && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // NOTE: pure datapath registers carry no reset; they are always written before being read.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && w_found) r_id <= w_win;
        if (r_state == S_CAPT) begin
            r_data <= w_word;
            r_exp  <= w_exp;
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.done_id = r_done_id;
    assign bus.par_out = r_par;
    assign bus.err     = r_err;
    assign bus.err_cnt = r_cnt;

endmodule

// File: tb/tb_parity_rr_sched.sv
// Scoreboard bench for parity_rr_sched: stimulus pushes expected results,
// a forked monitor pops and compares on every done strobe.
module tb_parity_rr_sched;
    localparam int NREQ = 4;
    localparam int DW   = 4;
    localparam int IDW  = 2;
    localparam int CW   = 3;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
        int   id;
        logic par;
        logic err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    parity_rr_sched_if #(.NREQ(NREQ), .DW(DW), .IDW(IDW), .CW(CW)) bus ();

    parity_rr_sched #(.NREQ(NREQ), .DW(DW), .IDW(IDW), .CW(CW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb_q[$];
    int   total   = 0;
    int   bad     = 0;
    int   exp_cnt = 0;

    task automatic check(input string name, input int act, input int want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_done(input int id, input logic [DW-1:0] w, input logic ep);
        exp_t e;
        e.id  = id;
        e.par = ^w;
        e.err = (^w) ^ ep;
        sb_q.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got id %0d want no done", bus.done_id);
                end else begin
                    e = sb_q.pop_front();
                    check("done_id", int'(bus.done_id), e.id);
                    check("par_out", int'(bus.par_out), int'(e.par));
                    check("err",     int'(bus.err),     int'(e.err));
                end
            end
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.done !== 1'b1 && n < 10);
        if (bus.done !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no done want done within 10 cycles", name);
        end
    endtask

    task automatic bump_cnt(input logic e, input logic clr);
        if (clr) exp_cnt = 0;
        else if (e && exp_cnt < CMAX) exp_cnt++;
    endtask

    // One isolated check by requester id; optionally drop req right after the grant
    // or pulse clr_cnt during the done cycle.
    task automatic run_one(input int id, input logic [DW-1:0] w, input logic ep,
                           input bit early_drop, input bit clr_at_done);
        logic [NREQ-1:0] oh;
        oh = '0;
        oh[id] = 1'b1;
        bus.data[id*DW +: DW] = w;
        bus.exp_par[id] = ep;
        bus.req = oh;
        expect_done(id, w, ep);
        tick();
        check("gnt_onehot", int'(bus.gnt), int'(oh));
        if (early_drop) bus.req = '0;
        wait_done("run_one");
        bus.req = '0;
        if (clr_at_done) bus.clr_cnt = 1'b1;
        tick();
        bus.clr_cnt = 1'b0;
        bump_cnt((^w) ^ ep, clr_at_done);
        check("err_cnt", int'(bus.err_cnt), exp_cnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int rr_order[5];
        logic [NREQ-1:0] oh;
        rr_order = '{0, 1, 2, 3, 0};

        fork
            monitor();
        join_none

        rst = 1'b1;
        bus.req = '0;
        bus.data = '0;
        bus.exp_par = '0;
        bus.clr_cnt = 1'b0;
        repeat (2) tick();
        rst = 1'b0;

        check("rst_gnt",     int'(bus.gnt), 0);
        check("rst_busy",    int'(bus.busy), 0);
        check("rst_done",    int'(bus.done), 0);
        check("rst_done_id", int'(bus.done_id), 0);
        check("rst_par_out", int'(bus.par_out), 0);
        check("rst_err",     int'(bus.err), 0);
        check("rst_err_cnt", int'(bus.err_cnt), 0);

        // Matching parity, then a mismatch on requester 2.
        run_one(0, 4'b0111, 1'b1, 1'b0, 1'b0);
        run_one(2, 4'b0011, 1'b1, 1'b0, 1'b0);

        // All four requesting from reset: grants 0,1,2,3,0 every third cycle.
        rst = 1'b1;
        bus.req = 4'b1111;
        bus.data = {4'b1111, 4'b0111, 4'b0011, 4'b0001};
        bus.exp_par = 4'b1101;
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        expect_done(0, 4'b0001, 1'b1);
        expect_done(1, 4'b0011, 1'b0);
        expect_done(2, 4'b0111, 1'b1);
        expect_done(3, 4'b1111, 1'b1);
        expect_done(0, 4'b0001, 1'b1);
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (c % 3 == 1) begin
                oh = '0;
                oh[rr_order[(c - 1) / 3]] = 1'b1;
                check("rr_gnt", int'(bus.gnt), int'(oh));
                check("rr_busy", int'(bus.busy), 1);
            end else if (c % 3 == 0) begin
                check("rr_done", int'(bus.done), 1);
                check("rr_gnt_in_done", int'(bus.gnt), 0);
            end
        end
        bus.req = '0;
        tick();
        bump_cnt(1'b1, 1'b0);
        check("rr_err_cnt", int'(bus.err_cnt), exp_cnt);

        // Saturation: clear, then nine mismatches on requester 1.
        bus.clr_cnt = 1'b1;
        tick();
        bus.clr_cnt = 1'b0;
        exp_cnt = 0;
        check("clr_err_cnt", int'(bus.err_cnt), 0);
        for (int i = 0; i < 9; i++) run_one(1, 4'b0001, 1'b0, 1'b0, 1'b0);
        check("sat_err_cnt", int'(bus.err_cnt), CMAX);
        run_one(1, 4'b0001, 1'b0, 1'b0, 1'b1);

        // Reset during CAPT drops the transaction and rewinds the pointer.
        bus.req = 4'b0010;
        bus.data[1*DW +: DW] = 4'b1000;
        tick();
        check("capt_gnt", int'(bus.gnt), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req = '0;
        exp_cnt = 0;
        check("mid_rst_gnt",  int'(bus.gnt), 0);
        check("mid_rst_busy", int'(bus.busy), 0);
        check("mid_rst_cnt",  int'(bus.err_cnt), 0);
        repeat (5) tick();
        check("mid_rst_no_done", int'(bus.done), 0);

        bus.data[1*DW +: DW] = 4'b0101;
        bus.data[3*DW +: DW] = 4'b1110;
        bus.exp_par = 4'b1000;
        bus.req = 4'b1010;
        expect_done(1, 4'b0101, 1'b0);
        expect_done(3, 4'b1110, 1'b1);
        tick();
        check("ptr0_gnt", int'(bus.gnt), 4'b0010);
        wait_done("ptr0_first");
        bus.req = 4'b1000;
        tick();
        check("ptr0_second_gnt", int'(bus.gnt), 4'b1000);
        wait_done("ptr0_second");
        bus.req = '0;
        tick();
        check("ptr0_err_cnt", int'(bus.err_cnt), 0);

        // Grant survives requester 3 dropping req in CAPT.
        run_one(3, 4'b1011, 1'b0, 1'b1, 1'b0);

        repeat (3) tick();
        check("sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
